seq_pattern_tx: RTL

//  Serial pattern transmitter: the driving end of the serial bit-sequence detector.

---
 rtl/seq_pattern_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first with repeat count
// Optional even-parity bit per pass: define SEQ_TX_PARITY_EN.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             bit_en,
    output logic             seq_bit,
    output logic             seq_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = PAT_W + 1;
`else
    localparam int FRAME_LEN = PAT_W;
`endif
    localparam int POS_W = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q, pat_nxt;
    logic [PAT_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] pass_q, pass_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic             seq_bit_nxt, seq_valid_nxt, frame_start_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            shreg       <= '0;
            pass_q      <= '0;
            pos         <= '0;
            seq_bit     <= 1'b0;
            seq_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pat_q       <= pat_nxt;
            shreg       <= shreg_nxt;
            pass_q      <= pass_nxt;
            pos         <= pos_nxt;
            seq_bit     <= seq_bit_nxt;
            seq_valid   <= seq_valid_nxt;
            frame_start <= frame_start_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pat_nxt         = pat_q;
        shreg_nxt       = shreg;
        pass_nxt        = pass_q;
        pos_nxt         = pos;
        seq_bit_nxt     = seq_bit;
        seq_valid_nxt   = 1'b0;
        frame_start_nxt = 1'b0;
        busy_nxt        = busy;
        done_nxt        = 1'b0;

        case (state)
            IDLE: begin
                seq_bit_nxt = 1'b0;
                if (start) begin
                    pat_nxt   = pattern;
                    shreg_nxt = pattern;
                    pass_nxt  = repeat_cnt;
                    pos_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = (repeat_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    seq_bit_nxt = 1'b0;
                end else if (bit_en) begin
                    seq_valid_nxt   = 1'b1;
                    frame_start_nxt = (pos == '0);
`ifdef SEQ_TX_PARITY_EN
                    if (pos == LAST_POS) begin
                        seq_bit_nxt = ^pat_q;
                    end else begin
                        seq_bit_nxt = shreg[PAT_W-1];
                        shreg_nxt   = {shreg[PAT_W-2:0], 1'b0};
                    end
`else
                    seq_bit_nxt = shreg[PAT_W-1];
                    shreg_nxt   = {shreg[PAT_W-2:0], 1'b0};
`endif
                    if (pos == LAST_POS) begin
                        // End of pass: reload the shifter so the next MSB follows with no gap.
                        pos_nxt   = '0;
                        shreg_nxt = pat_q;
                        if (pass_q != '0)
                            pass_nxt = pass_q - CNT_W'(1);
                        if (pass_q <= CNT_W'(1))
                            state_nxt = DONE;
                    end else begin
                        pos_nxt = pos + POS_W'(1);
                    end
                end
            end
            DONE: begin
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                seq_bit_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
